// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch controller: FSM state encoding and
// the default wrong-path squash length.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_SQUASH = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam int FLUSH_CYCLES_DEF = 2;
    localparam int SQ_CNT_W         = 8;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control bundle between the fetch controller and the rest of the pipeline
// (branch/hazard/decode inputs, PC and flush controls out).
interface fetch_ctrl_if;
    logic        br_taken;
    logic [15:0] br_target;
    logic        hlt_instr;
    logic        stall_req;
    logic        mem_busy;
    logic        pc_hold;
    logic        pc_src;
    logic [15:0] pc_target;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic [7:0]  stall_cycles;

    modport master (
        output br_taken, br_target, hlt_instr, stall_req, mem_busy,
        input  pc_hold, pc_src, pc_target, flush_if, flush_id, halted, stall_cycles
    );

    modport slave (
        input  br_taken, br_target, hlt_instr, stall_req, mem_busy,
        output pc_hold, pc_src, pc_target, flush_if, flush_id, halted, stall_cycles
    );
endinterface

// File: rtl/fetch_ctrl_sat_cnt8.sv
// 8-bit up counter that sticks at 8'hFF instead of wrapping.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= 8'h00;
        else if (en && cnt != 8'hFF)
            cnt <= cnt + 8'h01;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: arbitrates branch redirect, halt and stall for the PC and
// squashes wrong-path instructions in IF/ID and ID/EX after a taken branch.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input logic         clk,
    input logic         rst_n,
    fetch_ctrl_if.slave bus
);

    localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(FLUSH_CYCLES - 1);

    state_e              state;
    logic [SQ_CNT_W-1:0] sq_cnt;
    logic                halted_q;

    logic        pc_hold;
    logic        pc_src;
    logic [15:0] pc_target;
    logic        flush;
    logic        run_like;
    logic        hold_req;

    assign run_like = (state == ST_RUN) || (state == ST_STALL);
    assign hold_req = bus.stall_req || bus.mem_busy;

    // Redirect beats halt beats stall; SQUASH ignores branch/halt since they
    // come from wrong-path instructions.
    always_comb begin
        pc_hold   = 1'b0;
        pc_src    = 1'b0;
        pc_target = 16'h0000;
        flush     = 1'b0;
        case (state)
            ST_RUN, ST_STALL: begin
                if (bus.br_taken) begin
                    pc_src    = 1'b1;
                    pc_target = bus.br_target;
                    flush     = 1'b1;
                end else if (bus.hlt_instr || hold_req) begin
                    pc_hold = 1'b1;
                end
            end
            ST_SQUASH: begin
                flush   = 1'b1;
                pc_hold = bus.mem_busy;
            end
            ST_HALTED: pc_hold = 1'b1;
            default: ;
        endcase
    end

    // The resolve cycle itself counts toward the squash length, so SQUASH
    // exits once the counter has stepped down through 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            sq_cnt   <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_STALL: begin
                    if (bus.br_taken) begin
                        state  <= ST_SQUASH;
                        sq_cnt <= SQ_LOAD;
                    end else if (bus.hlt_instr) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (hold_req) begin
                        state <= ST_STALL;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt != '0)
                        sq_cnt <= sq_cnt - 1'b1;
                    if (sq_cnt <= SQ_CNT_W'(1) && !bus.mem_busy)
                        state <= ST_RUN;
                end
                ST_HALTED: ;
                default: state <= ST_RUN;
            endcase
        end
    end

    sat_cnt8 u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_hold && run_like),
        .cnt   (bus.stall_cycles)
    );

    assign bus.pc_hold   = pc_hold;
    assign bus.pc_src    = pc_src;
    assign bus.pc_target = pc_target;
    assign bus.flush_if  = flush;
    assign bus.flush_id  = flush;
    assign bus.halted    = halted_q;

endmodule
